// File: rtl/bus_wr_logger_pkg.sv
// Shared constants and types for the bus write logger.
// CSR offsets, STATUS bit positions and the log entry record.
package bus_wr_logger_pkg;

  localparam logic [3:0] CSR_CTRL      = 4'h0;
  localparam logic [3:0] CSR_STATUS    = 4'h4;
  localparam logic [3:0] CSR_HEAD_ADDR = 4'h8;
  localparam logic [3:0] CSR_HEAD_DATA = 4'hC;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;

  localparam int ST_CNT_W = 9;
  localparam int ST_FULL  = 9;
  localparam int ST_EMPTY = 10;
  localparam int ST_OVF   = 11;

  // Fields sized for the widest supported bus; narrower
  // builds carry zeros in the upper bits.
  localparam int LOG_FIELD_W = 64;

  typedef struct packed {
    logic [LOG_FIELD_W-1:0] addr;
    logic [LOG_FIELD_W-1:0] data;
  } log_entry_t;

endpackage

// File: rtl/log_fifo.sv
// Circular log storage: entries, read/write pointers and
// occupancy count, with a synchronous clear.
module log_fifo
  import bus_wr_logger_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          arst_n_i,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  log_entry_t    entry_i,
  output log_entry_t    head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  log_entry_t    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointer and count update; clear wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q] <= entry_i;
  end

  // Status flags and head entry.
  always_comb begin
    head_o  = mem_q[rd_ptr_q];
    full_o  = (count_q == CW'(DEPTH));
    empty_o = (count_q == '0);
    count_o = count_q;
  end

endmodule

// File: rtl/bus_wr_logger.sv
// Snoops bus writes into a circular log and exposes it
// through a small CSR slave (control, status, head pop).
module bus_wr_logger
  import bus_wr_logger_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              mon_req_i,
  input  logic              mon_ack_i,
  input  logic              mon_we_i,
  input  logic [ADDR_W-1:0] mon_addr_i,
  input  logic [DATA_W-1:0] mon_wdata_i,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [3:0]        host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_ack_o,
  output logic              host_resp_o,
  output logic [DATA_W-1:0] host_rdata_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic              en_q, en_d;
  logic              ovf_q, ovf_d;
  logic              resp_q, resp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              rd_acc, wr_acc;
  logic              cap, pop, push, clr, ovf_set;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  log_entry_t        push_entry, head;
  logic [DATA_W-1:0] status;
  logic              unused_wdata;

  assign unused_wdata = ^host_wdata_i[DATA_W-1:2];

  // Host access decode and capture / pop arbitration.
  always_comb begin
    host_ack_o = host_req_i;
    rd_acc  = host_req_i & ~host_we_i;
    wr_acc  = host_req_i & host_we_i;
    clr     = wr_acc & (host_addr_i == CSR_CTRL)
            & host_wdata_i[CTRL_CLR];
    cap     = mon_req_i & mon_ack_i & mon_we_i & en_q;
    pop     = rd_acc & (host_addr_i == CSR_HEAD_DATA)
            & ~fifo_empty;
    push    = cap & (~fifo_full | pop) & ~clr;
    ovf_set = cap & fifo_full & ~pop & ~clr;
    push_entry.addr = LOG_FIELD_W'(mon_addr_i);
    push_entry.data = LOG_FIELD_W'(mon_wdata_i);
  end

  log_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .clr_i    (clr),
    .push_i   (push),
    .pop_i    (pop),
    .entry_i  (push_entry),
    .head_o   (head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  // Control state and registered read data.
  always_comb begin
    status = '0;
    status[ST_CNT_W-1:0] = ST_CNT_W'(fifo_count);
    status[ST_FULL]      = fifo_full;
    status[ST_EMPTY]     = fifo_empty;
    status[ST_OVF]       = ovf_q;

    en_d = en_q;
    if (wr_acc && host_addr_i == CSR_CTRL)
      en_d = host_wdata_i[CTRL_EN];
    ovf_d = clr ? 1'b0 : (ovf_q | ovf_set);

    resp_d  = rd_acc;
    rdata_d = '0;
    if (rd_acc) begin
      unique case (host_addr_i)
        CSR_CTRL:      rdata_d = DATA_W'(en_q);
        CSR_STATUS:    rdata_d = status;
        CSR_HEAD_ADDR:
          if (!fifo_empty) rdata_d = DATA_W'(head.addr);
        CSR_HEAD_DATA:
          if (!fifo_empty) rdata_d = DATA_W'(head.data);
        default:       rdata_d = '0;
      endcase
    end
  end

  // Control and response registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      en_q    <= 1'b0;
      ovf_q   <= 1'b0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      en_q    <= en_d;
      ovf_q   <= ovf_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
    end
  end

  assign host_resp_o  = resp_q;
  assign host_rdata_o = rdata_q;

endmodule

// File: tb/tb_bus_wr_logger.sv
// Self-checking bench for bus_wr_logger: vector table plus
// hand-built sequences, read responses checked via a queue.
module tb_bus_wr_logger;

  logic        clk = 1'b0;
  logic        arst_n_i;
  logic        mon_req_i, mon_ack_i, mon_we_i;
  logic [31:0] mon_addr_i, mon_wdata_i;
  logic        host_req_i, host_we_i;
  logic [3:0]  host_addr_i;
  logic [31:0] host_wdata_i;
  logic        host_ack_o, host_resp_o;
  logic [31:0] host_rdata_o;

  always #5 clk = ~clk;

  bus_wr_logger #(
    .DEPTH  (8),
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk_i        (clk),
    .arst_n_i     (arst_n_i),
    .mon_req_i    (mon_req_i),
    .mon_ack_i    (mon_ack_i),
    .mon_we_i     (mon_we_i),
    .mon_addr_i   (mon_addr_i),
    .mon_wdata_i  (mon_wdata_i),
    .host_req_i   (host_req_i),
    .host_we_i    (host_we_i),
    .host_addr_i  (host_addr_i),
    .host_wdata_i (host_wdata_i),
    .host_ack_o   (host_ack_o),
    .host_resp_o  (host_resp_o),
    .host_rdata_o (host_rdata_o)
  );

  typedef struct {
    bit          h;
    bit          hwe;
    logic [3:0]  ha;
    logic [31:0] hd;
    bit          m;
    bit          mack;
    bit          mwe;
    logic [31:0] ma;
    logic [31:0] md;
    logic [31:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] exp;
    string       name;
  } sb_t;

  sb_t  sb[$];
  vec_t tbl[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  bit   mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: a response is due exactly one edge after
  // the read was presented; otherwise outputs must idle.
  always @(negedge clk) begin : monitor
    sb_t e;
    if (mon_on) begin
      compared++;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        if (host_resp_o !== 1'b1 || host_rdata_o !== e.exp) begin
          mismatched++;
          $display("FAIL %s: resp=%0b rdata=0x%0h, required resp=1 rdata=0x%0h",
                   e.name, host_resp_o, host_rdata_o, e.exp);
        end
      end else if (host_resp_o !== 1'b0 || host_rdata_o !== 32'h0) begin
        mismatched++;
        $display("FAIL idle_out @%0d: resp=%0b rdata=0x%0h, required 0/0",
                 cyc, host_resp_o, host_rdata_o);
      end
    end
  end

  task automatic idle();
    host_req_i   = 1'b0;
    host_we_i    = 1'b0;
    host_addr_i  = 4'h0;
    host_wdata_i = 32'h0;
    mon_req_i    = 1'b0;
    mon_ack_i    = 1'b0;
    mon_we_i     = 1'b0;
    mon_addr_i   = 32'h0;
    mon_wdata_i  = 32'h0;
  endtask

  function automatic vec_t nop();
    vec_t v;
    v.h = 0; v.hwe = 0; v.ha = 4'h0; v.hd = 32'h0;
    v.m = 0; v.mack = 0; v.mwe = 0;
    v.ma = 32'h0; v.md = 32'h0; v.exp = 32'h0;
    v.name = "nop";
    return v;
  endfunction

  function automatic vec_t rd(logic [3:0] a, logic [31:0] e,
                              string n);
    vec_t v;
    v = nop();
    v.h = 1; v.ha = a; v.exp = e; v.name = n;
    return v;
  endfunction

  function automatic vec_t wr(logic [3:0] a, logic [31:0] d);
    vec_t v;
    v = nop();
    v.h = 1; v.hwe = 1; v.ha = a; v.hd = d; v.name = "wr";
    return v;
  endfunction

  function automatic vec_t snp(logic [31:0] a, logic [31:0] d,
                               bit rq, bit ak, bit we);
    vec_t v;
    v = nop();
    v.m = rq; v.mack = ak; v.mwe = we;
    v.ma = a; v.md = d; v.name = "snoop";
    return v;
  endfunction

  // One cycle of stimulus; reads queue their expectation.
  task automatic step(input vec_t v);
    @(negedge clk);
    host_req_i   = v.h;
    host_we_i    = v.hwe;
    host_addr_i  = v.ha;
    host_wdata_i = v.hd;
    mon_req_i    = v.m;
    mon_ack_i    = v.mack;
    mon_we_i     = v.mwe;
    mon_addr_i   = v.ma;
    mon_wdata_i  = v.md;
    if (v.h && !v.hwe) sb.push_back('{cyc + 1, v.exp, v.name});
    #1;
    if (v.h) begin
      compared++;
      if (host_ack_o !== 1'b1) begin
        mismatched++;
        $display("FAIL ack_%s: ack=%0b, required 1", v.name, host_ack_o);
      end
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t v;
    idle();
    arst_n_i = 1'b1;
    #2 arst_n_i = 1'b0;
    #1 mon_on = 1'b1;
    repeat (3) @(negedge clk);
    arst_n_i = 1'b1;

    // Basic capture / disabled / CSR map vectors.
    tbl.push_back(rd(4'h0, 32'h0,   "rst_ctrl"));
    tbl.push_back(rd(4'h4, 32'h400, "rst_status"));
    tbl.push_back(snp(32'h40, 32'hAA, 1, 1, 1));
    tbl.push_back(rd(4'h4, 32'h400, "dis_status"));
    tbl.push_back(wr(4'h0, 32'h1));
    tbl.push_back(rd(4'h0, 32'h1,   "en_ctrl"));
    tbl.push_back(snp(32'h44, 32'hBB, 1, 1, 0));
    tbl.push_back(snp(32'h48, 32'hCC, 1, 0, 1));
    tbl.push_back(snp(32'h4C, 32'hDD, 0, 1, 1));
    tbl.push_back(rd(4'h4, 32'h400, "rd_only_status"));
    tbl.push_back(snp(32'h04, 32'h111111, 1, 1, 1));
    tbl.push_back(snp(32'h10, 32'h222222, 1, 1, 1));
    tbl.push_back(snp(32'h14, 32'h333333, 1, 1, 1));
    tbl.push_back(rd(4'h4, 32'h3,   "cnt3_status"));
    tbl.push_back(rd(4'h8, 32'h04,  "head_addr0"));
    tbl.push_back(wr(4'h4, 32'hFFFF));
    tbl.push_back(wr(4'h8, 32'hFFFF));
    tbl.push_back(rd(4'h4, 32'h3,   "ro_write_status"));
    tbl.push_back(rd(4'h1, 32'h0,   "unmapped_1"));
    tbl.push_back(rd(4'hE, 32'h0,   "unmapped_e"));
    tbl.push_back(rd(4'hC, 32'h111111, "pop0"));
    tbl.push_back(rd(4'h8, 32'h10,  "head_addr1"));
    tbl.push_back(rd(4'hC, 32'h222222, "pop1"));
    tbl.push_back(rd(4'hC, 32'h333333, "pop2"));
    tbl.push_back(rd(4'h4, 32'h400, "drained_status"));
    tbl.push_back(rd(4'hC, 32'h0,   "empty_pop"));
    tbl.push_back(rd(4'h8, 32'h0,   "empty_head"));
    tbl.push_back(rd(4'h4, 32'h400, "empty_status"));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Overflow: ten captures into eight slots.
    for (int i = 0; i < 10; i++)
      step(snp(32'(i * 4), 32'h1000 + 32'(i), 1, 1, 1));
    step(rd(4'h4, 32'hA08, "ovf_status"));
    for (int i = 0; i < 8; i++)
      step(rd(4'hC, 32'h1000 + 32'(i), "ovf_pop"));
    step(rd(4'h4, 32'hC00, "ovf_drained"));
    step(wr(4'h0, 32'h3));
    step(rd(4'h4, 32'h400, "ovf_cleared"));
    step(rd(4'h0, 32'h1,   "en_after_clr"));

    // Pop at full together with a capture.
    for (int i = 0; i < 8; i++)
      step(snp(32'h100 + 32'(i), 32'h2000 + 32'(i), 1, 1, 1));
    v = rd(4'hC, 32'h2000, "popcap_pop");
    v.m = 1; v.mack = 1; v.mwe = 1;
    v.ma = 32'h108; v.md = 32'h2008;
    step(v);
    step(rd(4'h4, 32'h208, "popcap_status"));
    for (int i = 1; i < 9; i++)
      step(rd(4'hC, 32'h2000 + 32'(i), "popcap_drain"));
    step(rd(4'h4, 32'h400, "popcap_empty"));

    // Clear with five entries and a same-cycle capture.
    for (int i = 0; i < 5; i++)
      step(snp(32'h300 + 32'(i * 4), 32'h3000 + 32'(i), 1, 1, 1));
    v = rd(4'h8, 32'h300, "inflight_head");
    v.m = 1; v.mack = 1; v.mwe = 1;
    v.ma = 32'h3F0; v.md = 32'h3FFF;
    step(v);
    step(rd(4'h4, 32'h6, "cnt6_status"));
    v = wr(4'h0, 32'h3);
    v.m = 1; v.mack = 1; v.mwe = 1;
    v.ma = 32'h3F4; v.md = 32'h3EEE;
    step(v);
    step(rd(4'h4, 32'h400, "clr_status"));
    step(rd(4'h0, 32'h1,   "clr_ctrl"));
    step(rd(4'hC, 32'h0,   "clr_pop"));
    step(rd(4'h4, 32'h400, "clr_status2"));
    step(wr(4'h0, 32'h2));
    step(rd(4'h0, 32'h0,   "clr_en0"));
    step(snp(32'h50, 32'h55, 1, 1, 1));
    step(rd(4'h4, 32'h400, "en0_status"));

    // Reset right after a HEAD_DATA read is accepted.
    step(wr(4'h0, 32'h1));
    step(snp(32'h60, 32'h6666, 1, 1, 1));
    step(snp(32'h64, 32'h7777, 1, 1, 1));
    @(negedge clk);
    host_req_i  = 1'b1;
    host_addr_i = 4'hC;
    @(posedge clk);
    #1;
    arst_n_i = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    arst_n_i = 1'b1;
    repeat (2) @(negedge clk);
    step(rd(4'h0, 32'h0,   "rst2_ctrl"));
    step(rd(4'h4, 32'h400, "rst2_status"));
    step(rd(4'h8, 32'h0,   "rst2_head"));
    step(rd(4'hC, 32'h0,   "rst2_pop"));

    repeat (3) @(negedge clk);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL sb_drain: %0d responses outstanding, required 0",
               sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bus_wr_logger.md
BUS_WR_LOGGER -- requirements
Module: bus_wr_logger

Interface
REQ-001 Parameter DEPTH, default 8: number of log entries; power of two, 2..256.
REQ-002 Parameter ADDR_W, default 32: width of the snooped address.
REQ-003 Parameter DATA_W, default 32: width of the snooped data and of the CSR port.
REQ-004 clk_i  in  1  single clock; all state in this block is clocked on its rising edge.
REQ-005 arst_n_i  in  1  reset, asynchronous assert and active-low.
REQ-006 mon_req_i, mon_ack_i, mon_we_i  in  1 each  snooped bus handshake.
REQ-007 mon_addr_i  in  ADDR_W  snooped address; mon_wdata_i  in  DATA_W  snooped write data.
REQ-008 host_req_i, host_we_i  in  1 each  CSR slave request and write-enable.
REQ-009 host_addr_i  in  4  CSR byte offset; host_wdata_i  in  DATA_W  CSR write data.
REQ-010 host_ack_o  out  1  CSR request accepted.
REQ-011 host_resp_o  out  1  read data valid; host_rdata_o  out  DATA_W  read data.

Function
REQ-012 Capture event: mon_req_i & mon_ack_i & mon_we_i high in one cycle while CTRL.en = 1.
- Pushes {mon_addr_i, mon_wdata_i} into a DEPTH-entry circular buffer.
- One entry per cycle; no other logging.
REQ-013 CSR map:
- 0x0 CTRL: bit0 en (R/W); bit1 clr (write-1, self-clearing, reads 0).
- 0x4 STATUS (RO): [8:0] count; bit9 full; bit10 empty; bit11 ovf (sticky).
- 0x8 HEAD_ADDR (RO): address of the oldest entry; non-destructive read.
- 0xC HEAD_DATA (RO): data of the oldest entry; the read pops that entry.
REQ-014 host_ack_o = host_req_i, combinational.
REQ-015 Read response:
- host_resp_o pulses exactly 1 cycle after an accepted read.
- host_rdata_o holds the data for that cycle and is 0 otherwise.
REQ-016 Reads of HEAD_ADDR or HEAD_DATA while the buffer is empty return 0, with no pop and no pointer change.
REQ-017 Writes to read-only offsets are ignored; unmapped offsets read as 0.
REQ-018 Capture while full:
- Entry is dropped and ovf is set.
- Exception: a HEAD_DATA pop in the same cycle frees a slot; the pop is applied first, the capture is accepted, and count is unchanged.
REQ-019 Simultaneous capture and pop when not empty: count is unchanged and both pointers advance.
REQ-020 clr:
- Zeroes the pointers, count and ovf in the cycle after the write.
- A capture in that same cycle is discarded.
- en is written from host_wdata_i[0] by the same access.
REQ-021 Pointers wrap modulo DEPTH; count saturates at DEPTH (full); full = (count == DEPTH).
REQ-022 A capture never alters the HEAD_ADDR/HEAD_DATA value of an in-flight read response; rdata is registered at the request edge.

Reset
REQ-023 On arst_n_i low, without waiting for a clock edge:
- en = 0, pointers = 0, count = 0, ovf = 0.
- host_resp_o = 0 and host_rdata_o = 0.
- Buffer contents are left undefined.
REQ-024 Reset asserted mid-read: the pending response is cancelled and no host_resp_o pulse follows deassertion.

Structure
REQ-025 Package bus_wr_logger_pkg holds:
- CSR offset constants and STATUS bit-index constants;
- the log-entry struct {addr, data}.
REQ-026 Storage, pointers and count live in one sub-module, log_fifo (push, pop, full, empty, count, head).
REQ-027 The CSR decode and the capture logic live in bus_wr_logger.

Verification
REQ-028 Capture: en=1; snoop writes 0x04/0x111111, 0x10/0x222222, 0x14/0x333333 -> STATUS count=3; HEAD_ADDR=0x04; HEAD_DATA reads 0x111111, 0x222222, 0x333333 in order, then empty=1.
REQ-029 Disabled/reads: en=0, or mon_we_i=0 -> no entries logged, count stays 0.
REQ-030 Overflow: DEPTH=8, 10 captures -> count=8, full=1, ovf=1; pops return only the first 8 data values.
REQ-031 Pop at full plus capture in the same cycle -> count stays 8; the 9th value is the last one popped.
REQ-032 Clear: write CTRL=0x3 with 5 entries logged -> next cycle count=0, ovf=0, en=1; HEAD_DATA reads 0 with no pop.
REQ-033 Reset: assert arst_n_i one cycle after a HEAD_DATA read -> no resp pulse; all CSRs read their reset values.
